// File: rtl/e300_dac_arbiter_if.sv
// rtl/e300_dac_arbiter_if.sv - request and AD5662 serial bundle for the DAC arbiter
interface e300_dac_arbiter_if;
  logic [15:0] loop_dat;
  logic        loop_valid;
  logic [15:0] host_dat;
  logic        host_valid;
  logic        host_ready;
  logic        host_override;
  logic        sclk;
  logic        mosi;
  logic        sync_n;
  logic        busy;
  logic        frame_done;
  logic [15:0] last_dat;
  logic        last_src;
  logic [7:0]  loop_drop_cnt;

  modport master (
    output loop_dat, loop_valid, host_dat, host_valid, host_override,
    input  host_ready, sclk, mosi, sync_n, busy, frame_done, last_dat, last_src, loop_drop_cnt
  );

  modport slave (
    input  loop_dat, loop_valid, host_dat, host_valid, host_override,
    output host_ready, sclk, mosi, sync_n, busy, frame_done, last_dat, last_src, loop_drop_cnt
  );
endinterface

// File: rtl/e300_dac_arbiter.sv
// rtl/e300_dac_arbiter.sv - two-source arbiter feeding an AD5662 serial DAC
module e300_dac_arbiter #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8,
  parameter logic [15:0] BOOT_DAT   = 16'd32767
) (
  input logic          clk,
  input logic          reset_n,
  e300_dac_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;          // cycles left in the current half-bit / setup / gap
  logic [4:0]  bit_idx, bit_idx_d;
  logic        phase, phase_d;      // 0: sclk low half, 1: sclk high half
  logic [23:0] sr, sr_d;            // frame shifter, sr[23] is the bit on mosi
  logic [15:0] cur_dat, cur_dat_d;
  logic        cur_src, cur_src_d;

  logic [15:0] loop_slot, host_slot;
  logic        loop_pend, host_pend;
  logic        host_rdy;
  logic [7:0]  drop_cnt;
  logic        grant_host, grant_loop;

  logic        sync_d, sclk_d, mosi_d, busy_d, done_d;
  logic        sync_q, sclk_q, mosi_q, busy_q, done_q;
  logic [15:0] last_dat_q;
  logic        last_src_q;

  // Host wins; loop is served only when the host is not overriding it
  assign grant_host = (state == IDLE) && host_pend;
  assign grant_loop = (state == IDLE) && !host_pend && loop_pend && !bus.host_override;

  // Single-entry request slots; a new loop code always replaces the old one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_slot <= BOOT_DAT;
      loop_pend <= 1'b1;
      host_slot <= '0;
      host_pend <= 1'b0;
      host_rdy  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (bus.loop_valid) begin
        loop_slot <= bus.loop_dat;
        loop_pend <= 1'b1;
        if (loop_pend && !grant_loop && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end else if (grant_loop) begin
        loop_pend <= 1'b0;
      end
      if (grant_host) begin
        host_pend <= 1'b0;
      end else if (bus.host_valid && host_rdy) begin
        host_slot <= bus.host_dat;
        host_pend <= 1'b1;
      end
      host_rdy <= grant_host || (!host_pend && !(bus.host_valid && host_rdy));
    end
  end

  // State register; serial outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      phase      <= 1'b1;
      sr         <= '0;
      cur_dat    <= '0;
      cur_src    <= 1'b0;
      sync_q     <= 1'b1;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_dat_q <= '0;
      last_src_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      phase   <= phase_d;
      sr      <= sr_d;
      cur_dat <= cur_dat_d;
      cur_src <= cur_src_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (done_d) begin
        last_dat_q <= cur_dat;
        last_src_q <= cur_src;
      end
    end
  end

  // Next-state: a started frame runs to completion regardless of requests
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    phase_d   = phase;
    sr_d      = sr;
    cur_dat_d = cur_dat;
    cur_src_d = cur_src;
    case (state)
      IDLE: begin
        if (grant_host || grant_loop) begin
          state_d   = SETUP;
          cnt_d     = DIV_LOAD;
          cur_dat_d = grant_host ? host_slot : loop_slot;
          cur_src_d = grant_host;
          sr_d      = {8'h00, cur_dat_d};
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_d   = SHIFT;
          phase_d   = 1'b0;
          bit_idx_d = '0;
          cnt_d     = DIV_LOAD;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      SHIFT: begin
        if (cnt != 8'd0) begin
          cnt_d = cnt - 8'd1;
        end else if (!phase) begin
          // rising sclk: the DAC has sampled this bit, present the next one
          phase_d = 1'b1;
          sr_d    = {sr[22:0], 1'b0};
          cnt_d   = DIV_LOAD;
        end else if (bit_idx == 5'd23) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          phase_d   = 1'b0;
          bit_idx_d = bit_idx + 5'd1;
          cnt_d     = DIV_LOAD;
        end
      end
      GAP: begin
        if (cnt == 8'd0) state_d = IDLE;
        else             cnt_d   = cnt - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the next state, captured by the state register
  always_comb begin
    sync_d = !(state_d == SETUP || state_d == SHIFT);
    sclk_d = !(state_d == SHIFT && !phase_d);
    mosi_d = sync_d ? 1'b0 : sr_d[23];
    busy_d = (state_d != IDLE);
    done_d = (state_d == GAP) && (state != GAP);
  end

  assign bus.host_ready    = host_rdy;
  assign bus.sclk          = sclk_q;
  assign bus.mosi          = mosi_q;
  assign bus.sync_n        = sync_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.last_dat      = last_dat_q;
  assign bus.last_src      = last_src_q;
  assign bus.loop_drop_cnt = drop_cnt;
endmodule
